// File: rtl/shift_reg_frame_sequencer.sv
// Frame sequencer for the pixel shift-register chain: shifts a latched pattern
// MSB-first using two non-overlapping clock phases, then strobes hold and sr_reset.
module shift_reg_frame_sequencer #(
  parameter int DIV       = 50000,
  parameter int NONOVL    = DIV / 3,
  parameter int PW        = 32,
  parameter int HOLD_CYC  = 16,
  parameter int RESET_CYC = 16
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [PW-1:0]             pattern,
  input  logic [$clog2(PW+1)-1:0]   bit_count,
  input  logic [7:0]                frame_count,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      out_clk_positive,
  output logic                      out_clk_negative,
  output logic                      d_out,
  output logic                      hold,
  output logic                      sr_reset
);

  localparam int BW = $clog2(PW + 1);
  localparam logic [BW-1:0] PW_W       = BW'(PW);
  localparam logic [31:0]   GAP_LAST   = 32'(NONOVL - 1);
  localparam logic [31:0]   PHASE_LAST = 32'(DIV - 1);
  localparam logic [31:0]   HOLD_LAST  = 32'(HOLD_CYC - 1);
  localparam logic [31:0]   RST_LAST   = 32'(RESET_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_PHI1, ST_GAP, ST_PHI2, ST_HOLD, ST_RST, ST_DONE
  } state_t;

  state_t          state;
  logic [31:0]     cnt;
  logic [PW-1:0]   pattern_q;
  logic [BW-1:0]   bit_count_q;
  logic [BW-1:0]   bit_idx;
  logic [7:0]      frames_left;
  logic            last;
  logic            start_bad;

  function automatic logic sel_bit(input logic [PW-1:0] pat, input logic [BW-1:0] idx);
    logic [PW-1:0] sh;
    sh = pat >> idx;
    return sh[0];
  endfunction

  // Every non-IDLE state ends when the duration counter reaches its limit.
  always_comb begin
    last = 1'b0;
    case (state)
      ST_SETUP, ST_GAP: last = (cnt == GAP_LAST);
      ST_PHI1, ST_PHI2: last = (cnt == PHASE_LAST);
      ST_HOLD:          last = (cnt == HOLD_LAST);
      ST_RST:           last = (cnt == RST_LAST);
      ST_DONE:          last = 1'b1;
      default:          last = 1'b0;
    endcase
  end

  always_comb begin
    start_bad = (bit_count == '0) || (bit_count > PW_W) || (frame_count == '0);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      pattern_q        <= '0;
      bit_count_q      <= '0;
      bit_idx          <= '0;
      frames_left      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      out_clk_positive <= 1'b0;
      out_clk_negative <= 1'b0;
      d_out            <= 1'b0;
      hold             <= 1'b0;
      sr_reset         <= 1'b0;
    end else if (state != ST_IDLE && abort) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      out_clk_positive <= 1'b0;
      out_clk_negative <= 1'b0;
      d_out            <= 1'b0;
      hold             <= 1'b0;
      sr_reset         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_IDLE || last) cnt <= '0;
      else                          cnt <= cnt + 32'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_bad) begin
              err <= 1'b1;
            end else begin
              pattern_q   <= pattern;
              bit_count_q <= bit_count;
              bit_idx     <= BW'(bit_count - 1'b1);
              frames_left <= frame_count;
              d_out       <= sel_bit(pattern, BW'(bit_count - 1'b1));
              busy        <= 1'b1;
              state       <= ST_SETUP;
            end
          end
        end
        ST_SETUP: if (last) begin
          out_clk_positive <= 1'b1;
          state            <= ST_PHI1;
        end
        ST_PHI1: if (last) begin
          out_clk_positive <= 1'b0;
          state            <= ST_GAP;
        end
        ST_GAP: if (last) begin
          out_clk_negative <= 1'b1;
          state            <= ST_PHI2;
        end
        ST_PHI2: if (last) begin
          out_clk_negative <= 1'b0;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            d_out   <= sel_bit(pattern_q, BW'(bit_idx - 1'b1));
            state   <= ST_SETUP;
          end else begin
            d_out <= 1'b0;
            hold  <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: if (last) begin
          hold     <= 1'b0;
          sr_reset <= 1'b1;
          state    <= ST_RST;
        end
        ST_RST: if (last) begin
          sr_reset    <= 1'b0;
          frames_left <= frames_left - 8'd1;
          if (frames_left != 8'd1) begin
            bit_idx <= BW'(bit_count_q - 1'b1);
            d_out   <= sel_bit(pattern_q, BW'(bit_count_q - 1'b1));
            state   <= ST_SETUP;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_frame_sequencer.sv
// Directed bench for shift_reg_frame_sequencer with small timing parameters.
module tb_shift_reg_frame_sequencer;

  localparam int DIV = 4, NONOVL = 1, PW = 8, HOLD_CYC = 2, RESET_CYC = 3;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] bit_count = '0;
  logic [7:0] frame_count = '0;
  logic busy, done, err, out_clk_positive, out_clk_negative, d_out, hold, sr_reset;

  int n_cmp = 0;
  int n_bad = 0;

  shift_reg_frame_sequencer #(
    .DIV(DIV), .NONOVL(NONOVL), .PW(PW), .HOLD_CYC(HOLD_CYC), .RESET_CYC(RESET_CYC)
  ) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .bit_count(bit_count), .frame_count(frame_count),
    .busy(busy), .done(done), .err(err),
    .out_clk_positive(out_clk_positive), .out_clk_negative(out_clk_negative),
    .d_out(d_out), .hold(hold), .sr_reset(sr_reset)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] all_outs();
    return {busy, done, err, out_clk_positive, out_clk_negative, d_out, hold, sr_reset};
  endfunction

  // Phase-relationship checks on every cycle of every test.
  logic m_ocp = 1'b0, m_ocn = 1'b0, m_d = 1'b0;
  always @(posedge clk_in) begin
    #1;
    chk("no_overlap", 32'(out_clk_positive & out_clk_negative), 32'd0);
    if (out_clk_positive && !m_ocp) chk("gap_before_pos", 32'(m_ocn), 32'd0);
    if (out_clk_negative && !m_ocn) chk("gap_before_neg", 32'(m_ocp), 32'd0);
    if (out_clk_positive || out_clk_negative) chk("d_stable_in_phase", 32'(d_out), 32'(m_d));
    m_ocp = out_clk_positive;
    m_ocn = out_clk_negative;
    m_d   = d_out;
  end

  task automatic run_frame(input string tag, input logic [7:0] pat, input logic [3:0] nb,
                           input logic [7:0] nf, input logic [7:0] exp_bits, input int exp_done);
    int t, pos_n, neg_n, hold_n, sr_n, done_n, done_t, busy_gaps, err_n;
    int prun, nrun, hrun, srun;
    logic [7:0] cap;
    pattern = pat; bit_count = nb; frame_count = nf; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    pattern = ~pat; bit_count = 4'd2; frame_count = 8'd9;
    t = 1; pos_n = 0; neg_n = 0; hold_n = 0; sr_n = 0; done_n = 0; done_t = -1;
    busy_gaps = 0; err_n = 0; prun = 0; nrun = 0; hrun = 0; srun = 0; cap = '0;
    while (t <= exp_done + 20) begin
      if (out_clk_positive) begin
        if (prun == 0) begin pos_n++; cap = {cap[6:0], d_out}; end
        prun++;
      end else if (prun != 0) begin chk({tag, "_pos_width"}, prun, DIV); prun = 0; end
      if (out_clk_negative) begin
        if (nrun == 0) neg_n++;
        nrun++;
      end else if (nrun != 0) begin chk({tag, "_neg_width"}, nrun, DIV); nrun = 0; end
      if (hold) begin
        if (hrun == 0) begin hold_n++; chk({tag, "_bits"}, cap, exp_bits); cap = '0; end
        hrun++;
        chk({tag, "_d_low_in_hold"}, d_out, 0);
      end else if (hrun != 0) begin chk({tag, "_hold_width"}, hrun, HOLD_CYC); hrun = 0; end
      if (sr_reset) begin
        if (srun == 0) sr_n++;
        srun++;
      end else if (srun != 0) begin chk({tag, "_sr_width"}, srun, RESET_CYC); srun = 0; end
      if (done) begin done_n++; if (done_t < 0) done_t = t; end
      if (t < exp_done && !busy) busy_gaps++;
      if (err) err_n++;
      if (done_t >= 0 && t >= done_t + 3) break;
      @(posedge clk_in); #1;
      t++;
    end
    chk({tag, "_done_cycle"}, done_t, exp_done);
    chk({tag, "_done_count"}, done_n, 1);
    chk({tag, "_pos_pulses"}, pos_n, nb * nf);
    chk({tag, "_neg_pulses"}, neg_n, nb * nf);
    chk({tag, "_hold_pulses"}, hold_n, nf);
    chk({tag, "_sr_pulses"}, sr_n, nf);
    chk({tag, "_busy_gaps"}, busy_gaps, 0);
    chk({tag, "_no_err"}, err_n, 0);
    chk({tag, "_idle_after"}, all_outs(), 8'h00);
  endtask

  task automatic reject(input string tag, input logic [3:0] nb, input logic [7:0] nf);
    bit_count = nb; frame_count = nf; pattern = 8'hFF; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    chk({tag, "_err_pulse"}, err, 1);
    chk({tag, "_no_activity"}, {busy, done, out_clk_positive, out_clk_negative, d_out, hold, sr_reset}, 0);
    @(posedge clk_in); #1;
    chk({tag, "_err_cleared"}, err, 0);
    chk({tag, "_still_idle"}, all_outs(), 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k, act;
    logic pv;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_outputs", all_outs(), 8'h00);
    reset = 1'b1;
    @(posedge clk_in); #1;
    chk("idle_after_release", all_outs(), 8'h00);

    run_frame("single", 8'hA5, 4'd8, 8'd1, 8'hA5, 86);
    run_frame("partial", 8'b0000_0101, 4'd3, 8'd1, 8'h05, 36);
    run_frame("multi", 8'hA5, 4'd8, 8'd3, 8'hA5, 256);

    // Abort in the 2nd PHI1 cycle of the third bit.
    pattern = 8'hA5; bit_count = 4'd8; frame_count = 8'd1; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    r = 0; k = 0; pv = 1'b0;
    while (k < 100) begin
      if (out_clk_positive && !pv) r++;
      pv = out_clk_positive;
      if (r == 3) break;
      @(posedge clk_in); #1;
      k++;
    end
    chk("abort_reached_bit3", r, 3);
    chk("abort_bit3_data", d_out, 1);
    @(posedge clk_in); #1;
    chk("abort_in_phi1", out_clk_positive, 1);
    abort = 1'b1;
    @(posedge clk_in); #1;
    abort = 1'b0;
    chk("abort_outputs_cleared", all_outs(), 8'h00);
    act = 0;
    repeat (12) begin
      @(posedge clk_in); #1;
      if (done || busy || out_clk_positive || hold) act++;
    end
    chk("abort_stays_quiet", act, 0);
    run_frame("restart", 8'hA5, 4'd8, 8'd1, 8'hA5, 86);

    reject("reject_bc0", 4'd0, 8'd1);
    reject("reject_bc9", 4'd9, 8'd1);
    reject("reject_fc0", 4'd4, 8'd0);

    // Async reset in the middle of a PHI2 phase.
    pattern = 8'hA5; bit_count = 4'd8; frame_count = 8'd1; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    k = 0;
    while (k < 100 && !out_clk_negative) begin
      @(posedge clk_in); #1;
      k++;
    end
    chk("reset_reached_phi2", out_clk_negative, 1);
    @(posedge clk_in); #3;
    reset = 1'b0;
    #1;
    chk("async_reset_immediate", all_outs(), 8'h00);
    @(posedge clk_in); #1;
    reset = 1'b1;
    act = 0;
    repeat (12) begin
      @(posedge clk_in); #1;
      if (busy || out_clk_positive || out_clk_negative || hold || sr_reset || done) act++;
    end
    chk("idle_after_async_reset", act, 0);
    run_frame("post_reset", 8'b0000_0101, 4'd3, 8'd1, 8'h05, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
